// File: rtl/approx_ctrl_pkg.sv
// Shared sizes, FSM states and the approx-mask helper
// for the approximate carry-save sequencer.
package approx_ctrl_pkg;

   localparam int NUM_OPS = 8;
   localparam int OP_W    = 8;
   localparam int SUM_W   = 11;
   localparam int IDX_W   = 3;

   typedef enum logic [1:0] {
      IDLE,
      REDUCE,
      FINAL,
      DONE
   } state_t;

   // Columns below n use the approximate carry; n >= SUM_W covers them all.
   function automatic logic [SUM_W-1:0] approx_mask(input logic [3:0] n);
      logic [SUM_W-1:0] m;
      m = '0;
      for (int k = 0; k < SUM_W; k++) begin
         m[k] = (k < int'(n));
      end
      return m;
   endfunction

endpackage

// File: rtl/approx_csa_sequencer_csa_row.sv
// One row of eleven full adders; masked columns drop the
// operand bit from the carry term.
module csa_row
   import approx_ctrl_pkg::*;
(
   input  logic [SUM_W-1:0] s_in,
   input  logic [SUM_W-1:0] c_in,
   input  logic [SUM_W-1:0] op_in,
   input  logic [SUM_W-1:0] approx_mask,
   output logic [SUM_W-1:0] sum_out,
   output logic [SUM_W-1:0] carry_out
);

   always_comb begin
      sum_out   = '0;
      carry_out = '0;
      for (int k = 0; k < SUM_W; k++) begin
         sum_out[k] = s_in[k] ^ c_in[k] ^ op_in[k];
         if (approx_mask[k]) begin
            carry_out[k] = s_in[k] & c_in[k];
         end else begin
            carry_out[k] = (s_in[k] & c_in[k])
                         | (s_in[k] & op_in[k])
                         | (c_in[k] & op_in[k]);
         end
      end
   end

endmodule

// File: rtl/approx_csa_sequencer.sv
// Sequencer: accepts eight operands, reduces them one per cycle
// through a carry-save row, then resolves S + C exactly.
module approx_csa_sequencer
   import approx_ctrl_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_OPS*OP_W-1:0] in_data,
   input  logic [3:0]              approx_bits,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SUM_W-1:0]        out_sum,
   output logic                    busy
);

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_OPS*OP_W-1:0] ops_q, ops_d;
   logic [3:0]              ab_q, ab_d;
   logic [SUM_W-1:0]        s_q, s_d;
   logic [SUM_W-1:0]        c_q, c_d;
   logic [SUM_W-1:0]        sum_q, sum_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic                    busy_q, busy_d;

   logic [SUM_W-1:0] cur_op;
   logic [SUM_W-1:0] row_sum;
   logic [SUM_W-1:0] row_carry;

   assign cur_op = {{(SUM_W-OP_W){1'b0}},
                    ops_q[{idx_q, 3'b000} +: OP_W]};

   csa_row u_row (
      .s_in        (s_q),
      .c_in        (c_q),
      .op_in       (cur_op),
      .approx_mask (approx_mask(ab_q)),
      .sum_out     (row_sum),
      .carry_out   (row_carry)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      ops_d       = ops_q;
      ab_d        = ab_q;
      s_d         = s_q;
      c_d         = c_q;
      sum_d       = sum_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               ops_d      = in_data;
               ab_d       = approx_bits;
               s_d        = '0;
               c_d        = '0;
               idx_d      = '0;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = REDUCE;
            end else begin
               in_ready_d = 1'b1;
            end
         end
         REDUCE: begin
            s_d   = row_sum;
            // Top-column carry falls off the 11-bit vector.
            c_d   = {row_carry[SUM_W-2:0], 1'b0};
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'(NUM_OPS-1)) begin
               state_d = FINAL;
            end
         end
         FINAL: begin
            sum_d       = s_q + c_q;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         ops_q       <= '0;
         ab_q        <= '0;
         s_q         <= '0;
         c_q         <= '0;
         sum_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         ops_q       <= ops_d;
         ab_q        <= ab_d;
         s_q         <= s_d;
         c_q         <= c_d;
         sum_q       <= sum_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = sum_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_approx_csa_sequencer.sv
// Self-checking bench: constant vectors, corner sequences and
// random sets against a column-rule reference model.
module tb_approx_csa_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [3:0]  approx_bits;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_sum;
   logic        busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   approx_csa_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .approx_bits (approx_bits),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .busy        (busy)
   );

   typedef struct {
      logic [63:0] d;
      logic [3:0]  ab;
      logic [10:0] exp;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Column-by-column carry-save reduction from the written rules.
   function automatic int ref_sum(input logic [63:0] d, input int ab);
      int s, c, ns, car, a, b, ci;
      s = 0;
      c = 0;
      for (int i = 0; i < 8; i++) begin
         ns  = 0;
         car = 0;
         for (int k = 0; k < 11; k++) begin
            a  = (s >> k) & 1;
            b  = (c >> k) & 1;
            ci = (k < 8) ? int'(d[8*i+k]) : 0;
            ns |= (a ^ b ^ ci) << k;
            if (k < ab) car |= (a & b) << k;
            else car |= ((a & b) | (a & ci) | (b & ci)) << k;
         end
         s = ns;
         c = (car << 1) & 'h7FF;
      end
      return (s + c) & 'h7FF;
   endfunction

   function automatic int exact_sum(input logic [63:0] d);
      int t = 0;
      for (int i = 0; i < 8; i++) t += int'(d[8*i +: 8]);
      return t;
   endfunction

   task automatic do_op(input logic [63:0] d, input logic [3:0] ab,
                        input int hold, input bit noise,
                        output logic [10:0] res);
      int n;
      logic [10:0] first;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_accept", in_ready, 1);
      in_valid    = 1'b1;
      in_data     = d;
      approx_bits = ab;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      n = 0;
      while (!out_valid && n < 20) begin
         if (noise) begin
            in_valid    = 1'($urandom);
            in_data     = {$urandom, $urandom};
            approx_bits = 4'($urandom);
            out_ready   = (n < 8) ? 1'($urandom) : 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("latency", n, 9);
      first = out_sum;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_sum", out_sum, first);
         chk("hold_in_ready", in_ready, 0);
      end
      res = out_sum;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("valid_after_hs", out_valid, 0);
      chk("in_ready_after_hs", in_ready, 1);
   endtask

   vec_t        vt[7];
   logic [10:0] res;
   logic [63:0] rd;
   logic [3:0]  rab;

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd0,  11'd2040};
      vt[1] = '{64'h0101_0101_0101_0101, 4'd0,  11'd8};
      vt[2] = '{64'h0101_0101_0101_0101, 4'd1,  11'd0};
      vt[3] = '{64'h0807_0605_0403_0201, 4'd0,  11'd36};
      vt[4] = '{64'h8080_8080_8080_8080, 4'd0,  11'd1024};
      vt[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd11, 11'd0};
      vt[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 11'd0};

      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      approx_bits = '0;
      out_ready   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("in_ready_post_rst", in_ready, 1);

      for (int i = 0; i < 7; i++) begin
         do_op(vt[i].d, vt[i].ab, 0, 1'b0, res);
         chk($sformatf("vec%0d", i), res, vt[i].exp);
      end

      do_op(64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 5, 1'b0, res);
      chk("hold_result", res, 2040);

      // Abort in the middle of REDUCE, then a clean run.
      @(negedge clk);
      in_valid    = 1'b1;
      in_data     = 64'hFFFF_FFFF_FFFF_FFFF;
      approx_bits = 4'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("busy_in_reduce", busy, 1);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_sum", out_sum, 0);
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      do_op(64'h0807_0605_0403_0201, 4'd0, 0, 1'b0, res);
      chk("after_abort", res, 36);

      for (int i = 0; i < 20; i++) begin
         rd = {$urandom, $urandom};
         do_op(rd, 4'd0, 0, 1'b1, res);
         chk("noise_sum", res, exact_sum(rd));
      end

      for (int i = 0; i < 1000; i++) begin
         rd = {$urandom, $urandom};
         do_op(rd, 4'd0, 0, 1'b0, res);
         chk("rand_exact", res, exact_sum(rd));
      end

      for (int i = 0; i < 100; i++) begin
         rd  = {$urandom, $urandom};
         rab = 4'($urandom_range(15, 0));
         do_op(rd, rab, 0, 1'b0, res);
         chk($sformatf("rand_approx_ab%0d", rab), res,
             ref_sum(rd, int'(rab)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
